// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   Operand forwarding and decode-stall generation for an in-order pipeline.
//   For every decode source it picks the youngest downstream stage that writes
//   the same register. It stalls decode on load-use hazards and on conflicts
//   with one outstanding fixed-latency multicycle op (mul/div). That op is
//   tracked by a small IDLE/BUSY scoreboard.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rs_D            NUM_SRC packed source addresses (src i at [i*REG_AW +: REG_AW])
//   rs_valid_D      per-source "actually read" flags
//   rd_D            decode destination
//   regwrite_D      decode instruction writes rd_D
//   mc_req_D        decode instruction is a multicycle op
//   stage_rd        NUM_FWD packed stage destinations (0 = youngest)
//   stage_regwrite  per-stage write enable
//   stage_is_load   per-stage "result not ready yet" (load in flight)
//   mc_issue        multicycle op leaves decode this cycle
//   mc_rd           destination of the issuing multicycle op
//   fwd_sel         per source: 0 regfile, k stage k-1, NUM_FWD+1 multicycle result
//   stall_D         hold F/D, inject bubble into X
//   mc_busy         scoreboard occupied
//   mc_wb_valid     multicycle result on the writeback bus this cycle
//   mc_wb_rd        destination of that result (0 when not valid)
//
// Optional build macro FWD_HAZARD_PERF_EN:
//   Adds perf_stall_cnt / perf_fwd_cnt saturating 32-bit event counters.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter  int NUM_SRC = 2,
    parameter  int NUM_FWD = 2,
    parameter  int REG_AW  = 5,
    parameter  int MC_LAT  = 4,
    localparam int SEL_W   = $clog2(NUM_FWD + 2)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*REG_AW-1:0]  rs_D,
    input  logic [NUM_SRC-1:0]         rs_valid_D,
    input  logic [REG_AW-1:0]          rd_D,
    input  logic                       regwrite_D,
    input  logic                       mc_req_D,
    input  logic [NUM_FWD*REG_AW-1:0]  stage_rd,
    input  logic [NUM_FWD-1:0]         stage_regwrite,
    input  logic [NUM_FWD-1:0]         stage_is_load,
    input  logic                       mc_issue,
    input  logic [REG_AW-1:0]          mc_rd,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall_D,
    output logic                       mc_busy,
    output logic                       mc_wb_valid,
    output logic [REG_AW-1:0]          mc_wb_rd
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_fwd_cnt
`endif
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);
    localparam logic [SEL_W-1:0] SEL_MC   = SEL_W'(NUM_FWD + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Scoreboard state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [REG_AW-1:0]  rd_q,    rd_d;
    logic               busy_q,  busy_d;
    logic               wbv_q,   wbv_d;

    // Forwarding / hazard combinational signals
    logic [NUM_SRC*SEL_W-1:0] sel_c;
    logic [REG_AW-1:0]        rs_c;
    logic [SEL_W-1:0]         src_sel_c;
    logic                     found_c;
    logic                     load_stall_c;
    logic                     raw_hit_c;
    logic                     waw_hit_c;
    logic                     sb_block_c;
    logic                     stall_c;

    // ------------------------------------------------------------------
    // Per-source forward select. Stages are scanned from youngest to
    // oldest; the first hit wins, so an older match is shadowed. A load
    // stall is raised only for the winning stage.
    // ------------------------------------------------------------------
    always_comb begin
        sel_c        = '0;
        rs_c         = '0;
        src_sel_c    = '0;
        found_c      = 1'b0;
        load_stall_c = 1'b0;
        raw_hit_c    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_c      = rs_D[i*REG_AW +: REG_AW];
            src_sel_c = '0;
            found_c   = 1'b0;
            if (rs_valid_D[i] && (rs_c != '0)) begin
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!found_c && stage_regwrite[k] &&
                        (stage_rd[k*REG_AW +: REG_AW] == rs_c)) begin
                        found_c   = 1'b1;
                        src_sel_c = SEL_W'(k + 1);
                        if (stage_is_load[k]) begin
                            load_stall_c = 1'b1;
                        end
                    end
                end
                // Multicycle result on the wb bus is the lowest-priority source.
                if (!found_c && wbv_q && (rd_q == rs_c)) begin
                    src_sel_c = SEL_MC;
                end
                // rs_c is nonzero here, so a stored rd of 0 can never match.
                if (rd_q == rs_c) begin
                    raw_hit_c = 1'b1;
                end
            end
            sel_c[i*SEL_W +: SEL_W] = src_sel_c;
        end
    end

    // Scoreboard conflicts only matter while the op is still computing;
    // in the wb cycle the result is forwardable and the slot frees up.
    assign sb_block_c = busy_q && !wbv_q;
    assign waw_hit_c  = regwrite_D && (rd_D == rd_q) && (rd_q != '0);
    assign stall_c    = load_stall_c ||
                        (sb_block_c && (raw_hit_c || waw_hit_c || mc_req_D));

    // Outputs are forced low while reset is held, including the
    // combinational ones.
    assign fwd_sel     = rst ? '0 : sel_c;
    assign stall_D     = stall_c && !rst;
    assign mc_busy     = busy_q;
    assign mc_wb_valid = wbv_q;
    assign mc_wb_rd    = wbv_q ? rd_q : '0;

    // ------------------------------------------------------------------
    // Scoreboard next state. An issue while counting down is a protocol
    // error and is dropped; an issue in the wb cycle reloads the slot.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        unique case (state_q)
            S_IDLE: begin
                if (mc_issue) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                    rd_d    = mc_rd;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (mc_issue) begin
                    cnt_d = CNT_LOAD;
                    rd_d  = mc_rd;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status flags are registered so they come straight from flops.
        busy_d = (state_d == S_BUSY);
        wbv_d  = (state_d == S_BUSY) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            wbv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            wbv_q   <= wbv_d;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Saturating event counters: stall cycles, and cycles that actually
    // forward (any nonzero select while decode advances).
    // ------------------------------------------------------------------
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_fwd_q,   perf_fwd_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_fwd_d   = perf_fwd_q;
        if (stall_D && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (!stall_D && (fwd_sel != '0) && (perf_fwd_q != '1)) begin
            perf_fwd_d = perf_fwd_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_fwd_q   <= perf_fwd_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_fwd_cnt   = perf_fwd_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int REG_AW  = 5;
    localparam int MC_LAT  = 4;
    localparam int SEL_W   = 2;
    localparam int OBS_W   = NUM_SRC*SEL_W + 3 + REG_AW;

    typedef logic [OBS_W-1:0] obs_t;

    typedef struct {
        logic [4:0] rs2, rs1;
        logic [1:0] rsv;
        logic       rw;
        logic [4:0] rd;
        logic       req;
        logic [4:0] srd1, srd0;
        logic [1:0] srw, sld;
        logic       iss;
        logic [4:0] mrd;
        obs_t       e;
    } step_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC*REG_AW-1:0] rs_D;
    logic [NUM_SRC-1:0]        rs_valid_D;
    logic [REG_AW-1:0]         rd_D;
    logic                      regwrite_D;
    logic                      mc_req_D;
    logic [NUM_FWD*REG_AW-1:0] stage_rd;
    logic [NUM_FWD-1:0]        stage_regwrite;
    logic [NUM_FWD-1:0]        stage_is_load;
    logic                      mc_issue;
    logic [REG_AW-1:0]         mc_rd;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall_D;
    logic                      mc_busy;
    logic                      mc_wb_valid;
    logic [REG_AW-1:0]         mc_wb_rd;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]               perf_stall_cnt;
    logic [31:0]               perf_fwd_cnt;
`endif

    obs_t obs;
    obs_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    assign obs = {fwd_sel, stall_D, mc_busy, mc_wb_valid, mc_wb_rd};

    fwd_hazard_unit #(
        .NUM_SRC(NUM_SRC),
        .NUM_FWD(NUM_FWD),
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs_D          (rs_D),
        .rs_valid_D    (rs_valid_D),
        .rd_D          (rd_D),
        .regwrite_D    (regwrite_D),
        .mc_req_D      (mc_req_D),
        .stage_rd      (stage_rd),
        .stage_regwrite(stage_regwrite),
        .stage_is_load (stage_is_load),
        .mc_issue      (mc_issue),
        .mc_rd         (mc_rd),
        .fwd_sel       (fwd_sel),
        .stall_D       (stall_D),
        .mc_busy       (mc_busy),
        .mc_wb_valid   (mc_wb_valid),
        .mc_wb_rd      (mc_wb_rd)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_fwd_cnt  (perf_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector: {sel src1, sel src0, stall, busy, wb_valid, wb_rd}
    function automatic obs_t mk(input logic [1:0] s1, input logic [1:0] s0,
                                input logic st, input logic bz, input logic wv,
                                input logic [4:0] wrd);
        return {s1, s0, st, bz, wv, wrd};
    endfunction

    function automatic step_t st(input logic [4:0] rs2, input logic [4:0] rs1,
                                 input logic [1:0] rsv, input logic rw,
                                 input logic [4:0] rd, input logic req,
                                 input logic [4:0] srd1, input logic [4:0] srd0,
                                 input logic [1:0] srw, input logic [1:0] sld,
                                 input logic iss, input logic [4:0] mrd,
                                 input obs_t e);
        step_t s;
        s.rs2 = rs2; s.rs1 = rs1; s.rsv = rsv; s.rw = rw; s.rd = rd; s.req = req;
        s.srd1 = srd1; s.srd0 = srd0; s.srw = srw; s.sld = sld;
        s.iss = iss; s.mrd = mrd; s.e = e;
        return s;
    endfunction

    task automatic clear_inputs();
        rs_D = '0; rs_valid_D = '0; rd_D = '0; regwrite_D = 1'b0; mc_req_D = 1'b0;
        stage_rd = '0; stage_regwrite = '0; stage_is_load = '0;
        mc_issue = 1'b0; mc_rd = '0;
    endtask

    // Drive one cycle of stimulus and enqueue what the outputs must show.
    task automatic apply(input step_t s);
        rs_D           = {s.rs2, s.rs1};
        rs_valid_D     = s.rsv;
        rd_D           = s.rd;
        regwrite_D     = s.rw;
        mc_req_D       = s.req;
        stage_rd       = {s.srd1, s.srd0};
        stage_regwrite = s.srw;
        stage_is_load  = s.sld;
        mc_issue       = s.iss;
        mc_rd          = s.mrd;
        exp_q.push_back(s.e);
    endtask

    task automatic test_reset();
        step_t s[$];
        obs_t  e;
        // Forwarding match, load and issue all present: reset must mask everything.
        s.push_back(st(5,5,2'b11, 0,0, 0, 0,5,2'b01,2'b01, 1,9, mk(0,0,0,0,0,0)));
        s.push_back(st(5,5,2'b11, 0,0, 0, 0,5,2'b01,2'b01, 1,9, mk(0,0,0,0,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_forward();
        step_t s[$];
        obs_t  e;
        s.push_back(st(5,5,2'b11, 0,0, 0, 5,5,2'b11,2'b00, 0,0, mk(1,1,0,0,0,0)));
        s.push_back(st(5,5,2'b11, 0,0, 0, 0,0,2'b11,2'b00, 0,0, mk(0,0,0,0,0,0)));
        s.push_back(st(5,5,2'b11, 0,0, 0, 5,0,2'b11,2'b00, 0,0, mk(2,2,0,0,0,0)));
        s.push_back(st(5,5,2'b01, 0,0, 0, 0,5,2'b01,2'b00, 0,0, mk(0,1,0,0,0,0)));
        s.push_back(st(5,5,2'b11, 0,0, 0, 0,5,2'b00,2'b00, 0,0, mk(0,0,0,0,0,0)));
        s.push_back(st(3,5,2'b11, 0,0, 0, 3,5,2'b11,2'b00, 0,0, mk(2,1,0,0,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL forward[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        obs_t  e;
        s.push_back(st(0,7,2'b01, 0,0, 0, 0,7,2'b01,2'b01, 0,0, mk(0,1,1,0,0,0)));
        s.push_back(st(0,7,2'b01, 0,0, 0, 7,7,2'b11,2'b10, 0,0, mk(0,1,0,0,0,0)));
        s.push_back(st(0,7,2'b01, 0,0, 0, 7,0,2'b10,2'b10, 0,0, mk(0,2,1,0,0,0)));
        s.push_back(st(7,0,2'b10, 0,0, 0, 0,7,2'b01,2'b01, 0,0, mk(1,0,1,0,0,0)));
        s.push_back(st(0,0,2'b11, 0,0, 0, 0,0,2'b11,2'b11, 0,0, mk(0,0,0,0,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL load_use[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_multicycle();
        step_t s[$];
        obs_t  e;
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 1,9, mk(0,0,0,0,0,0)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,1,1,0,0)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,1,1,0,0)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,1,1,0,0)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,3,0,1,1,9)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,0,0,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL multicycle[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        obs_t  e;
        // WAW and structural stalls, then reissue in the wb cycle.
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 1,9,  mk(0,0,0,0,0,0)));
        s.push_back(st(0,0,2'b00, 1,9, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,1,1,0,0)));
        s.push_back(st(0,0,2'b00, 0,0, 1, 0,0,2'b00,2'b00, 0,0,  mk(0,0,1,1,0,0)));
        s.push_back(st(0,0,2'b00, 1,8, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,0,1,0,0)));
        s.push_back(st(0,0,2'b00, 1,9, 1, 0,0,2'b00,2'b00, 1,12, mk(0,0,0,1,1,9)));
        // Second op: RAW on 12, stray issue while counting is ignored.
        s.push_back(st(0,12,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,1,1,0,0)));
        s.push_back(st(0,12,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 1,13, mk(0,0,1,1,0,0)));
        s.push_back(st(0,12,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,1,1,0,0)));
        s.push_back(st(0,12,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,3,0,1,1,12)));
        s.push_back(st(0,12,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,0,0,0,0)));
        // Op with rd 0: occupies the slot, no WAW match, structural still stalls.
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 1,0,  mk(0,0,0,0,0,0)));
        s.push_back(st(0,0,2'b11, 1,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,0,1,0,0)));
        s.push_back(st(0,0,2'b00, 0,0, 1, 0,0,2'b00,2'b00, 0,0,  mk(0,0,1,1,0,0)));
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,0,1,0,0)));
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,0,1,1,0)));
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 0,0,  mk(0,0,0,0,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_busy();
        step_t s[$];
        step_t p[$];
        obs_t  e;
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 1,9, mk(0,0,0,0,0,0)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,1,1,0,0)));
        s.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,1,1,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL rst_mid[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        // Counter is 2 here; reset asynchronously between edges.
        #1 rst = 1'b1;
        exp_q.push_back(mk(0,0,0,0,0,0));
        #1;
        e = exp_q.pop_front(); n_total++;
        if (obs !== e) $display("FAIL rst_async: got %h expected %h", obs, e);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MC_LAT; i++) begin
            p.push_back(st(0,9,2'b01, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,0,0,0,0)));
        end
        foreach (p[i]) begin
            @(negedge clk); apply(p[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL rst_after[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        clear_inputs();
    endtask

`ifdef FWD_HAZARD_PERF_EN
    task automatic test_perf();
        step_t s[$];
        obs_t  e;
        logic [31:0] pexp[$];
        logic [31:0] pe;
        @(negedge clk); clear_inputs(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++)
            s.push_back(st(0,7,2'b01, 0,0, 0, 0,7,2'b01,2'b01, 0,0, mk(0,1,1,0,0,0)));
        for (int i = 0; i < 2; i++)
            s.push_back(st(0,7,2'b01, 0,0, 0, 0,7,2'b01,2'b00, 0,0, mk(0,1,0,0,0,0)));
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,0,0,0,0)));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL perf_seq[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        pexp.push_back(32'd3);
        pexp.push_back(32'd2);
        pe = pexp.pop_front(); n_total++;
        if (perf_stall_cnt !== pe) $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, pe);
        else n_pass++;
        pe = pexp.pop_front(); n_total++;
        if (perf_fwd_cnt !== pe) $display("FAIL perf_fwd: got %0d expected %0d", perf_fwd_cnt, pe);
        else n_pass++;
        // Preload near the top and run past it.
        @(negedge clk);
        force dut.perf_stall_q = 32'hFFFF_FFFE;
        force dut.perf_fwd_q   = 32'hFFFF_FFFE;
        #1;
        release dut.perf_stall_q;
        release dut.perf_fwd_q;
        s.delete();
        for (int i = 0; i < 3; i++)
            s.push_back(st(0,7,2'b01, 0,0, 0, 0,7,2'b01,2'b01, 0,0, mk(0,1,1,0,0,0)));
        for (int i = 0; i < 3; i++)
            s.push_back(st(0,7,2'b01, 0,0, 0, 0,7,2'b01,2'b00, 0,0, mk(0,1,0,0,0,0)));
        s.push_back(st(0,0,2'b00, 0,0, 0, 0,0,2'b00,2'b00, 0,0, mk(0,0,0,0,0,0)));
        foreach (s[i]) begin
            apply(s[i]); #2;
            e = exp_q.pop_front(); n_total++;
            if (obs !== e) $display("FAIL perf_sat_seq[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
            @(negedge clk);
        end
        pexp.push_back(32'hFFFF_FFFF);
        pexp.push_back(32'hFFFF_FFFF);
        pe = pexp.pop_front(); n_total++;
        if (perf_stall_cnt !== pe) $display("FAIL perf_stall_sat: got %h expected %h", perf_stall_cnt, pe);
        else n_pass++;
        pe = pexp.pop_front(); n_total++;
        if (perf_fwd_cnt !== pe) $display("FAIL perf_fwd_sat: got %h expected %h", perf_fwd_cnt, pe);
        else n_pass++;
        clear_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef FWD_HAZARD_PERF_EN
        test_perf();
`endif
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
